// File: rtl/tcm_dmem_router_if.sv
// Data-memory request/response bus shared by the core side and both router ports.
// The master drives the request fields; the slave answers with ack, read data and response.
interface tcm_dmem_router_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              cmd;
    logic [1:0]        width;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              req_ack;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/tcm_dmem_router.sv
// Steers core data requests to the TCM (port 0) or the external bus (port 1) by address,
// tracking one outstanding transaction and allowing a new accept in the response cycle.
module tcm_dmem_router #(
    parameter int              ADDR_W           = 32,
    parameter int              DATA_W           = 32,
    parameter logic [ADDR_W-1:0] TCM_ADDR_MASK    = 32'hFFFF0000,
    parameter logic [ADDR_W-1:0] TCM_ADDR_PATTERN = 32'h00480000
) (
    input  logic              clk,
    input  logic              rst,
    tcm_dmem_router_if.slave  core_bus,
    tcm_dmem_router_if.master p0_bus,
    tcm_dmem_router_if.master p1_bus
);

    localparam logic [1:0] RESP_NOTRDY = 2'b00;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              cur_port_q, cur_port_d;

    logic              sel;
    logic [1:0]        cur_resp;
    logic [DATA_W-1:0] cur_rdata;
    logic              in_wait;
    logic              resp_done;
    logic              can_issue;
    logic              accept;

    assign sel       = ((core_bus.addr & TCM_ADDR_MASK) != TCM_ADDR_PATTERN);
    assign cur_resp  = cur_port_q ? p1_bus.resp  : p0_bus.resp;
    assign cur_rdata = cur_port_q ? p1_bus.rdata : p0_bus.rdata;

    // Reset gates the combinational outputs so nothing leaks out while rst is held,
    // even though the registered state is already IDLE.
    assign in_wait   = (state_q == ST_WAIT) && !rst;
    assign resp_done = in_wait && (cur_resp != RESP_NOTRDY);
    assign can_issue = !rst && ((state_q == ST_IDLE) || resp_done);
    assign accept    = core_bus.req && core_bus.req_ack;

    assign core_bus.resp    = in_wait ? cur_resp  : RESP_NOTRDY;
    assign core_bus.rdata   = in_wait ? cur_rdata : '0;
    assign core_bus.req_ack = can_issue && (sel ? p1_bus.req_ack : p0_bus.req_ack);

    assign p0_bus.req   = core_bus.req && can_issue && !sel;
    assign p1_bus.req   = core_bus.req && can_issue && sel;
    assign p0_bus.cmd   = core_bus.cmd;
    assign p1_bus.cmd   = core_bus.cmd;
    assign p0_bus.width = core_bus.width;
    assign p1_bus.width = core_bus.width;
    assign p0_bus.addr  = core_bus.addr;
    assign p1_bus.addr  = core_bus.addr;
    assign p0_bus.wdata = core_bus.wdata;
    assign p1_bus.wdata = core_bus.wdata;

    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_WAIT;
                    cur_port_d = sel;
                end
            end
            ST_WAIT: begin
                // A response-cycle accept keeps us in WAIT with no bubble; the port may switch.
                if (resp_done) begin
                    if (accept) begin
                        cur_port_d = sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
        end
    end

endmodule

// File: doc/tcm_dmem_router.md
Name: tcm_dmem_router

Overview:
- Sits directly upstream of the TCM data port. Decodes each core data-memory request by address and steers it either to the TCM port (port 0) or to the external data bus port (port 1).
- Tracks one outstanding transaction and returns the matching response and read data to the core.
- Supports back-to-back pipelining: a new request is accepted in the same cycle the previous response returns. This sustains one access per cycle against the single-cycle TCM.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data width
- TCM_ADDR_MASK, 32'hFFFF0000, address bits compared for the TCM decode
- TCM_ADDR_PATTERN, 32'h00480000, value of (addr & mask) that selects port 0

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- core_req  in  1  core request valid
- core_cmd  in  1  0 = read, 1 = write
- core_width  in  2  00 byte, 01 halfword, 10 word
- core_addr  in  ADDR_W  byte address
- core_wdata  in  DATA_W  write data
- core_req_ack  out  1  request accepted this cycle
- core_rdata  out  DATA_W  read data, valid with the response
- core_resp  out  2  00 NOTRDY, 01 RDY_OK, 10 RDY_ER
- p0_req, p1_req  out  1  port request
- p0_cmd/p1_cmd, p0_width/p1_width, p0_addr/p1_addr, p0_wdata/p1_wdata  out  1/2/ADDR_W/DATA_W  forwarded request fields
- p0_req_ack, p1_req_ack  in  1  port accepted
- p0_rdata, p1_rdata  in  DATA_W  port read data
- p0_resp, p1_resp  in  2  port response (same encoding as core_resp)

Behaviour:
- Decode: sel = ((core_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN) ? port 0 : port 1. The decode is combinational.
- FSM states and meaning:
  - IDLE: no transaction outstanding.
  - WAIT: a transaction is outstanding; the port is recorded in the registered bit cur_port.
- Response completion: resp_done = (state == WAIT) && (resp of cur_port != NOTRDY).
- Core response path:
  - core_resp = resp of cur_port when in WAIT, otherwise NOTRDY.
  - core_rdata = rdata of cur_port when in WAIT, otherwise 0.
- Request window: can_issue = (state == IDLE) || resp_done.
- Request forwarding:
  - p0_req = core_req & can_issue & (sel == 0).
  - p1_req = core_req & can_issue & (sel == 1).
  - cmd, width, addr and wdata are driven to both ports unconditionally; only req is gated.
- Acceptance:
  - core_req_ack = can_issue & (sel ? p1_req_ack : p0_req_ack).
  - A transaction is accepted when core_req & core_req_ack.
- Transitions:
  - IDLE: on accept, go to WAIT and set cur_port <= sel; otherwise stay IDLE.
  - WAIT without resp_done: stay in WAIT. core_req_ack = 0 and both pN_req = 0, regardless of core_req.
  - WAIT with resp_done and a new accept: stay in WAIT and set cur_port <= sel. The port may switch; this is the back-to-back case, with zero bubble cycles.
  - WAIT with resp_done and no accept: go to IDLE.
- RDY_ER from either port is passed through unchanged and completes the transaction like RDY_OK.
- Latency: the router adds zero cycles in both directions. End-to-end latency equals the selected port's latency (TCM: response one cycle after accept).
- No outstanding-count overflow is possible: the router never holds more than one transaction.
- Reset, whether asserted mid-transaction or at any time:
  - state = IDLE, cur_port = 0.
  - Outputs: core_resp = NOTRDY, core_rdata = 0, core_req_ack = 0, p0_req = p1_req = 0.
  - A response arriving from a port after reset is ignored, because the router is in IDLE.
- Simultaneous core_req with a NOTRDY response in WAIT: the request is held off (req_ack = 0). The core must keep core_req and its fields stable until acked.
- Address at the decode boundary: 32'h0047FFFC selects port 1, 32'h00480000 selects port 0, 32'h0048FFFC selects port 0, 32'h00490000 selects port 1.

Test Plan:
- Single TCM read: addr 32'h00480010, p0 acks and returns RDY_OK with 32'hDEADBEEF one cycle later -> core_req_ack = 1 in cycle 0; core_resp = 01 and core_rdata = 32'hDEADBEEF in cycle 1; p1_req never asserted.
- Back-to-back with port switch: TCM write to 32'h00480000, then an external read at 32'h10000000 issued in the response cycle -> second request acked in the same cycle as the first response; p1 response data routed to the core while cur_port = 1.
- Slow external port: p1 returns NOTRDY for 3 cycles, then RDY_ER; core_req held to a TCM address meanwhile -> core_req_ack = 0 and p0_req = 0 for 3 cycles; core_resp = 10 on cycle 4; TCM request acked that same cycle.
- Boundary decode: addresses 32'h0047FFFC, 32'h00480000, 32'h0048FFFC, 32'h00490000 -> requests routed to p1, p0, p0, p1 respectively.
- Reset mid-transaction: assert rst while in WAIT on p1; p1 then returns RDY_OK -> all outputs at reset values immediately (asynchronously); core_resp stays 00 and the stale response is ignored; the first request after reset release is accepted normally.
- Port refusal: p0_req_ack = 0 for 2 cycles -> core_req_ack = 0 and state stays IDLE; accept occurs in cycle 2 and the response follows in cycle 3.
